// File: rtl/jump_input_pkg.sv
// Shared types and defaults for the jump-button input path.
// Holds the debounce state enum, default frame counts and the width of the
// frame counters used for debounce and cooldown.
package jump_input_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } key_state_t;

    localparam int DEF_DEBOUNCE_FRAMES = 2;
    localparam int DEF_COOLDOWN_FRAMES = 30;
    localparam int DEF_REPEAT_FRAMES   = 20;

    localparam int FRAME_CNT_W = 8;
    typedef logic [FRAME_CNT_W-1:0] frame_cnt_t;

    localparam frame_cnt_t FRAME_CNT_ZERO = {FRAME_CNT_W{1'b0}};
    localparam frame_cnt_t FRAME_CNT_ONE  = {{(FRAME_CNT_W-1){1'b0}}, 1'b1};

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchronizer plus whole-frame debouncer for the raw jump button.
// key_held is the registered stable level; rise_strobe is high during the
// cycle whose closing edge flips the stable level from IDLE to HELD, so the
// parent can register its reaction on that same edge.
module key_debouncer
    import jump_input_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES
) (
    input  logic frame_rt_clk,
    input  logic reset,
    input  logic btn_raw,
    output logic key_held,
    output logic rise_strobe
);

    // The flip happens on the edge where the count would reach
    // DEBOUNCE_FRAMES, i.e. when the stored count already equals one less.
    localparam frame_cnt_t DB_LAST = frame_cnt_t'(DEBOUNCE_FRAMES - 1);

    logic       r_s1;
    logic       r_btn_s;
    key_state_t r_state;
    key_state_t w_state_nxt;
    frame_cnt_t r_cnt;
    frame_cnt_t w_cnt_nxt;
    logic       w_differs;
    logic       w_flip;

    // Bring the asynchronous button into the frame clock domain.
    always_ff @(posedge frame_rt_clk or posedge reset) begin
        if (reset) begin
            r_s1    <= 1'b0;
            r_btn_s <= 1'b0;
        end else begin
            r_s1    <= btn_raw;
            r_btn_s <= r_s1;
        end
    end

    // Stable-level state and debounce run counter.
    always_ff @(posedge frame_rt_clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= FRAME_CNT_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Count consecutive disagreeing samples and flip once the run is long enough.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_flip      = 1'b0;
        w_differs   = (r_btn_s != (r_state == HELD));
        if (!w_differs) begin
            w_cnt_nxt = FRAME_CNT_ZERO;
        end else if (r_cnt == DB_LAST) begin
            w_flip    = 1'b1;
            w_cnt_nxt = FRAME_CNT_ZERO;
            case (r_state)
                IDLE:    w_state_nxt = HELD;
                HELD:    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end else begin
            w_cnt_nxt = r_cnt + FRAME_CNT_ONE;
        end
    end

    assign key_held    = (r_state == HELD);
    assign rise_strobe = w_flip && (r_state == IDLE);

endmodule

// File: rtl/jump_key_conditioner.sv
// Jump button conditioner: debounced press detection, single-frame jump_key
// pulse per accepted press, airborne cooldown, drop indication and press
// counter. Optional auto-repeat while held is enabled by JUMP_AUTOREPEAT_EN.
module jump_key_conditioner
    import jump_input_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES,
    parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
    parameter int REPEAT_FRAMES   = DEF_REPEAT_FRAMES,
    parameter int CNT_W           = 16
) (
    input  logic             frame_rt_clk,
    input  logic             reset,
    input  logic             btn_raw,
    input  logic             enable,
    output logic             jump_key,
    output logic             key_held,
    output logic             press_dropped,
    output logic [CNT_W-1:0] press_count
);

    localparam frame_cnt_t       CD_LOAD  = frame_cnt_t'(COOLDOWN_FRAMES);
    localparam frame_cnt_t       RPT_LOAD = frame_cnt_t'(REPEAT_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             w_held;
    logic             w_rise;
    logic             w_cd_zero;
    logic             w_accept;
    logic             w_drop;
    logic             w_repeat;
    logic             w_fire;
    frame_cnt_t       w_cd_nxt;
    frame_cnt_t       r_cooldown;
    logic             r_jump_key;
    logic             r_press_dropped;
    logic [CNT_W-1:0] r_press_count;

    key_debouncer #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debouncer (
        .frame_rt_clk(frame_rt_clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .key_held    (w_held),
        .rise_strobe (w_rise)
    );

    assign w_cd_zero = (r_cooldown == FRAME_CNT_ZERO);

    // Decide acceptance or drop at a debounced rise; enable matters only here.
    always_comb begin
        w_accept = 1'b0;
        w_drop   = 1'b0;
        if (w_rise) begin
            if (enable && w_cd_zero) begin
                w_accept = 1'b1;
            end else begin
                w_drop = 1'b1;
            end
        end else begin
            w_accept = 1'b0;
            w_drop   = 1'b0;
        end
    end

`ifdef JUMP_AUTOREPEAT_EN
    // Re-fire while the button stays held once the cooldown has run out.
    always_comb begin
        w_repeat = w_held && enable && w_cd_zero;
    end
`else
    // Without auto-repeat a held button never re-fires.
    always_comb begin
        w_repeat = 1'b0;
    end
`endif

    // Cooldown next value: a fresh load wins over the running decrement.
    always_comb begin
        w_fire   = w_accept || w_repeat;
        w_cd_nxt = r_cooldown;
        if (w_accept) begin
            w_cd_nxt = CD_LOAD;
        end else if (w_repeat) begin
            w_cd_nxt = RPT_LOAD;
        end else if (!w_cd_zero) begin
            w_cd_nxt = r_cooldown - FRAME_CNT_ONE;
        end else begin
            w_cd_nxt = r_cooldown;
        end
    end

    // Registered pulses, press counter and cooldown timer.
    always_ff @(posedge frame_rt_clk or posedge reset) begin
        if (reset) begin
            r_jump_key      <= 1'b0;
            r_press_dropped <= 1'b0;
            r_press_count   <= CNT_ZERO;
            r_cooldown      <= FRAME_CNT_ZERO;
        end else begin
            r_jump_key      <= w_fire;
            r_press_dropped <= w_drop;
            r_cooldown      <= w_cd_nxt;
            if (w_fire) begin
                r_press_count <= r_press_count + CNT_ONE;
            end else begin
                r_press_count <= r_press_count;
            end
        end
    end

    assign jump_key      = r_jump_key;
    assign press_dropped = r_press_dropped;
    assign press_count   = r_press_count;
    assign key_held      = w_held;

endmodule

// File: tb/tb_jump_key_conditioner.sv
// Scoreboard bench for jump_key_conditioner. The reference model works on
// the history of raw button samples: the stable level flips when the last
// DEBOUNCE_FRAMES synchronized samples all disagree with it, and cooldown is
// tracked as the first edge number at which presses are allowed again.
`timescale 1ns/1ps
module tb_jump_key_conditioner;

    localparam int D = 2;
    localparam int C = 30;
    localparam int R = 20;
    localparam int W = 16;

    logic         frame_rt_clk = 1'b0;
    logic         reset        = 1'b1;
    logic         btn_raw      = 1'b0;
    logic         enable       = 1'b1;
    logic         jump_key;
    logic         key_held;
    logic         press_dropped;
    logic [W-1:0] press_count;

    jump_key_conditioner #(
        .DEBOUNCE_FRAMES(D),
        .COOLDOWN_FRAMES(C),
        .REPEAT_FRAMES  (R),
        .CNT_W          (W)
    ) dut (
        .frame_rt_clk (frame_rt_clk),
        .reset        (reset),
        .btn_raw      (btn_raw),
        .enable       (enable),
        .jump_key     (jump_key),
        .key_held     (key_held),
        .press_dropped(press_dropped),
        .press_count  (press_count)
    );

    always #5 frame_rt_clk = ~frame_rt_clk;

    typedef struct packed {
        logic         jk;
        logic         pd;
        logic         kh;
        logic [W-1:0] pc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state
    bit           hist[$];
    bit           m_stable;
    logic [W-1:0] m_count;
    int           m_edge;
    int           m_cd_free_at;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Raw sample taken j edges before the most recent one; 0 before reset release.
    function automatic bit raw_at(int j);
        int idx;
        idx = hist.size() - 1 - j;
        if (idx < 0) return 1'b0;
        return hist[idx];
    endfunction

    task automatic model_reset();
        hist.delete();
        m_stable     = 1'b0;
        m_count      = '0;
        m_edge       = 0;
        m_cd_free_at = 0;
    endtask

    task automatic model_edge(bit b, bit e);
        bit   jk;
        bit   pd;
        bit   flip;
        bit   was_held;
        exp_t x;
        jk       = 1'b0;
        pd       = 1'b0;
        flip     = 1'b1;
        was_held = m_stable;
        m_edge++;
        hist.push_back(b);
        // Synchronized value seen at this edge is the raw sample two edges back.
        for (int j = 2; j <= D + 1; j++) begin
            if (raw_at(j) == m_stable) flip = 1'b0;
        end
        if (flip && !m_stable) begin
            if (e && m_edge >= m_cd_free_at) begin
                jk           = 1'b1;
                m_count      = m_count + 1'b1;
                m_cd_free_at = m_edge + C + 1;
            end else begin
                pd = 1'b1;
            end
        end
`ifdef JUMP_AUTOREPEAT_EN
        else if (was_held && e && m_edge >= m_cd_free_at) begin
            jk           = 1'b1;
            m_count      = m_count + 1'b1;
            m_cd_free_at = m_edge + R + 1;
        end
`endif
        if (flip) m_stable = !m_stable;
        x.jk = jk;
        x.pd = pd;
        x.kh = m_stable;
        x.pc = m_count;
        sb_q.push_back(x);
        if (was_held) begin end
    endtask

    task automatic step(bit b, bit e);
        btn_raw = b;
        enable  = e;
        @(posedge frame_rt_clk);
        model_edge(b, e);
        @(negedge frame_rt_clk);
    endtask

    task automatic steps(int n, bit b, bit e);
        for (int i = 0; i < n; i++) step(b, e);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_jump_key", 32'(jump_key), 32'd0);
        chk("rst_key_held", 32'(key_held), 32'd0);
        chk("rst_press_dropped", 32'(press_dropped), 32'd0);
        chk("rst_press_count", 32'(press_count), 32'd0);
        repeat (2) @(posedge frame_rt_clk);
        @(negedge frame_rt_clk);
        reset = 1'b0;
        sb_q.delete();
        model_reset();
    endtask

    // Monitor: compare every cycle's outputs against the oldest expectation.
    always @(negedge frame_rt_clk) begin
        exp_t e;
        if (!reset && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("jump_key", 32'(jump_key), 32'(e.jk));
            chk("press_dropped", 32'(press_dropped), 32'(e.pd));
            chk("key_held", 32'(key_held), 32'(e.kh));
            chk("press_count", 32'(press_count), 32'(e.pc));
        end
    end

    initial begin
        model_reset();
        reset   = 1'b1;
        btn_raw = 1'b0;
        enable  = 1'b1;
        repeat (3) @(posedge frame_rt_clk);
        #1;
        chk("init_jump_key", 32'(jump_key), 32'd0);
        chk("init_key_held", 32'(key_held), 32'd0);
        chk("init_press_dropped", 32'(press_dropped), 32'd0);
        chk("init_press_count", 32'(press_count), 32'd0);
        @(negedge frame_rt_clk);
        reset = 1'b0;

        // Press/release timing: rise before edge 10, hold 40 frames, release.
        steps(9, 1'b0, 1'b1);
        steps(40, 1'b1, 1'b1);
        steps(10, 1'b0, 1'b1);
`ifndef JUMP_AUTOREPEAT_EN
        chk("timing_count", 32'(press_count), 32'd1);
`endif

        // Glitch rejection: single-frame highs never register.
        do_reset();
        for (int g = 0; g < 5; g++) begin
            step(1'b1, 1'b1);
            steps(3, 1'b0, 1'b1);
        end
        steps(4, 1'b0, 1'b1);
        chk("glitch_count", 32'(press_count), 32'd0);
        chk("glitch_held", 32'(key_held), 32'd0);

        // Cooldown: press at 0 accepted, press at 10 dropped, press at 35 accepted.
        do_reset();
        steps(5, 1'b1, 1'b1);
        steps(5, 1'b0, 1'b1);
        steps(5, 1'b1, 1'b1);
        steps(20, 1'b0, 1'b1);
        steps(5, 1'b1, 1'b1);
        steps(10, 1'b0, 1'b1);
        chk("cooldown_count", 32'(press_count), 32'd2);

        // Enable gating: dropped with enable=0, then immediate accepted re-press.
        do_reset();
        steps(5, 1'b1, 1'b0);
        steps(5, 1'b0, 1'b0);
        chk("gate_count_dropped", 32'(press_count), 32'd0);
        steps(5, 1'b1, 1'b1);
        steps(5, 1'b0, 1'b1);
        chk("gate_count_accepted", 32'(press_count), 32'd1);

        // Reset mid-operation during the jump_key cycle with the button held.
        do_reset();
        steps(4, 1'b1, 1'b1);
        #1;
        chk("pre_reset_jump_key", 32'(jump_key), 32'd1);
        do_reset();
        steps(6, 1'b1, 1'b1);
        steps(5, 1'b0, 1'b1);
        chk("post_reset_count", 32'(press_count), 32'd1);

`ifdef JUMP_AUTOREPEAT_EN
        // Auto-repeat: hold 100 frames gives five pulses.
        do_reset();
        steps(100, 1'b1, 1'b1);
        steps(5, 1'b0, 1'b1);
        chk("repeat_count", 32'(press_count), 32'd5);
`endif

        // Randomized presses, gaps and enable against the model.
        do_reset();
        for (int it = 0; it < 150; it++) begin
            int len;
            int gap;
            len = $urandom_range(1, 8);
            gap = $urandom_range(1, 12);
            for (int k = 0; k < len; k++) step(1'b1, ($urandom_range(0, 9) > 1));
            for (int k = 0; k < gap; k++) step(1'b0, ($urandom_range(0, 9) > 1));
        end
        steps(3, 1'b0, 1'b1);
        #2;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
